ram_np: RTL

Parametrised N-port, single-clock synchronous RAM. It is the successor to the two-port block:
- generalised to NPORT ports;
- adds byte-enabled writes and a selectable read-during-write mode;
- adds a configurable read pipeline with a valid strobe;
- defines collision and out-of-range behaviour.

It sits between several controllers and one shared storage array. Each controller drives one port slice.

---
 rtl/ram_np.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ram_np.sv
// N-port single-clock synchronous RAM with byte enables, fixed-priority write
// arbitration, selectable read-during-write result and a 1- or 2-stage read pipeline.
module ram_np #(
  parameter int NPORT    = 2,
  parameter int DEPTH    = 256,
  parameter int AWID     = 8,
  parameter int DWID     = 16,
  parameter int BEWID    = DWID / 8,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NPORT-1:0]        en,
  input  logic [NPORT-1:0]        we,
  input  logic [NPORT*BEWID-1:0]  be,
  input  logic [NPORT*AWID-1:0]   addr,
  input  logic [NPORT*DWID-1:0]   din,
  output logic [NPORT*DWID-1:0]   dout,
  output logic [NPORT-1:0]        dvalid,
  output logic [NPORT-1:0]        wr_coll,
  output logic [NPORT-1:0]        oob_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWID:0] DEPTH_W = (AWID+1)'(DEPTH);

  function automatic logic [DWID-1:0] byte_merge(input logic [DWID-1:0] old_w,
                                                 input logic [DWID-1:0] new_w,
                                                 input logic [BEWID-1:0] b);
    logic [DWID-1:0] r;
    r = old_w;
    for (int i = 0; i < BEWID; i++)
      if (b[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  logic [DWID-1:0]  mem [DEPTH];

  logic [AWID-1:0]  a       [NPORT];
  logic [DWID-1:0]  d       [NPORT];
  logic [BEWID-1:0] b       [NPORT];
  logic [DWID-1:0]  old_w   [NPORT];
  logic [DWID-1:0]  rd_word [NPORT];
  logic [NPORT-1:0] in_rng, wr_act, win, coll, oob;

  // Decode, arbitrate (lowest writing port wins an address) and form read data.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      a[p]      = addr[p*AWID +: AWID];
      d[p]      = din[p*DWID +: DWID];
      b[p]      = be[p*BEWID +: BEWID];
      in_rng[p] = ({1'b0, a[p]} < DEPTH_W);
      wr_act[p] = rst_n & en[p] & we[p] & (|b[p]) & in_rng[p];
      old_w[p]  = in_rng[p] ? mem[a[p][IW-1:0]] : '0;
    end
    for (int p = 0; p < NPORT; p++) begin
      win[p] = wr_act[p];
      for (int q = 0; q < p; q++)
        if (wr_act[q] && (a[q] == a[p])) win[p] = 1'b0;
      coll[p] = wr_act[p] & ~win[p];
      oob[p]  = en[p] & ~in_rng[p];
    end
    for (int p = 0; p < NPORT; p++) begin
      rd_word[p] = old_w[p];
      if (RDW_MODE != 0)
        for (int q = 0; q < NPORT; q++)
          if (win[q] && in_rng[p] && (a[q] == a[p]))
            rd_word[p] = byte_merge(old_w[p], d[q], b[q]);
    end
  end

  // Storage: winners always target distinct addresses.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORT; p++)
      if (win[p]) mem[a[p][IW-1:0]] <= byte_merge(old_w[p], d[p], b[p]);
  end

  logic [NPORT-1:0] vld_p0, coll_p0, oob_p0;

  // Stage p0: request-side status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= '0;
      coll_p0 <= '0;
      oob_p0  <= '0;
    end else begin
      vld_p0  <= en;
      coll_p0 <= coll;
      oob_p0  <= oob;
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout <= '0;
      end else begin
        for (int p = 0; p < NPORT; p++)
          if (en[p]) dout[p*DWID +: DWID] <= rd_word[p];
      end
    end
    assign dvalid  = vld_p0;
    assign wr_coll = coll_p0;
    assign oob_err = oob_p0;
  end else begin : g_lat2
    logic [NPORT*DWID-1:0] rd_p0;
    logic [NPORT-1:0]      vld_p1, coll_p1, oob_p1;

    always_ff @(posedge clk) begin
      for (int p = 0; p < NPORT; p++)
        if (en[p]) rd_p0[p*DWID +: DWID] <= rd_word[p];
    end

    // Stage p1: extra output register; pipeline emptiness is carried by vld_p0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p1  <= '0;
        coll_p1 <= '0;
        oob_p1  <= '0;
        dout    <= '0;
      end else begin
        vld_p1  <= vld_p0;
        coll_p1 <= coll_p0;
        oob_p1  <= oob_p0;
        for (int p = 0; p < NPORT; p++)
          if (vld_p0[p]) dout[p*DWID +: DWID] <= rd_p0[p*DWID +: DWID];
      end
    end
    assign dvalid  = vld_p1;
    assign wr_coll = coll_p1;
    assign oob_err = oob_p1;
  end

endmodule
